// File: rtl/gnrl_pipe_slice_pkg.sv
// Purpose: shared constants and helpers for the gnrl_pipe_slice register slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gnrl_pipe_slice_pkg;

    localparam int MIN_DEPTH = 1;
    localparam int MAX_DEPTH = 8;

    // Width needed to hold an occupancy of 0..2*depth (main + skid per stage).
    function automatic int cnt_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/gnrl_pipe_skid_stage.sv
// Purpose: one main+skid register stage with valid/ready on both sides.
// Latency: 1 cycle from upstream acceptance to downstream valid.
// Backpressure: up_rdy is registered (!skid full); no comb path from dn_rdy to up_rdy.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   flush             drop the held beats at the next edge (data untouched)
//   up_vld/rdy/dat    upstream side of the stage
//   dn_vld/rdy/dat    downstream side, driven straight from the main register
module gnrl_pipe_skid_stage #(
    parameter int DW       = 32,
    parameter bit RST_DATA = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          up_vld,
    output logic          up_rdy,
    input  logic [DW-1:0] up_dat,
    output logic          dn_vld,
    input  logic          dn_rdy,
    output logic [DW-1:0] dn_dat
);

    logic          m_vld;
    logic          s_vld;
    logic [DW-1:0] m_dat;
    logic [DW-1:0] s_dat;
    logic          up_xfer;
    logic          dn_xfer;
    logic          m_free;

    assign up_rdy  = !s_vld;
    assign up_xfer = up_vld & !s_vld;
    assign dn_xfer = m_vld & dn_rdy;
    // Main can take a new beat when it is empty or its beat leaves this cycle.
    assign m_free  = dn_xfer | !m_vld;

    assign dn_vld = m_vld;
    assign dn_dat = m_dat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (flush) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (m_free) begin
            // Skid has priority over upstream; up_rdy was low so no up_xfer then.
            if (s_vld) begin
                m_vld <= 1'b1;
                s_vld <= 1'b0;
            end else begin
                m_vld <= up_xfer;
            end
        end else if (up_xfer) begin
            s_vld <= 1'b1;
        end
    end

    // Data path kept separate so flush never disturbs data and RST_DATA=0
    // leaves the data registers without a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (RST_DATA) begin
                m_dat <= '0;
                s_dat <= '0;
            end
        end else if (!flush) begin
            if (m_free) begin
                if (s_vld) begin
                    m_dat <= s_dat;
                end else if (up_xfer) begin
                    m_dat <= up_dat;
                end
            end else if (up_xfer) begin
                s_dat <= up_dat;
            end
        end
    end

endmodule

// File: rtl/gnrl_pipe_slice.sv
// Purpose: DEPTH-stage valid/ready register slice with skid buffers, flush and occupancy count.
// Latency: DEPTH cycles from i_valid sampled to o_valid on an empty, unstalled slice.
// Backpressure: full rate under o_ready=1; holds 2*DEPTH beats; i_ready registered (plus flush gate).
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   flush                      drop every held beat at the next edge; blocks input this cycle
//   i_valid/i_ready/i_data     producer side
//   o_valid/o_ready/o_data     consumer side
//   count                      beats currently held, 0..2*DEPTH
module gnrl_pipe_slice
    import gnrl_pipe_slice_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 2,
    parameter bit RST_DATA = 1'b0,
    parameter int CW       = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] count
);

    // Index i is the input side of stage i; index DEPTH is the slice output.
    logic [DEPTH:0]         vld;
    logic [DEPTH:0]         rdy;
    logic [DEPTH:0][DW-1:0] dat;

    logic          up_xfer;
    logic          dn_xfer;
    logic [CW-1:0] count_q;

    // Flush gates the producer so nothing is taken in the cycle being dropped.
    assign vld[0]     = i_valid & !flush;
    assign dat[0]     = i_data;
    assign rdy[DEPTH] = o_ready;

    assign i_ready = rdy[0] & !flush;
    assign o_valid = vld[DEPTH];
    assign o_data  = dat[DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        gnrl_pipe_skid_stage #(
            .DW       (DW),
            .RST_DATA (RST_DATA)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (flush),
            .up_vld (vld[g]),
            .up_rdy (rdy[g]),
            .up_dat (dat[g]),
            .dn_vld (vld[g+1]),
            .dn_rdy (rdy[g+1]),
            .dn_dat (dat[g+1])
        );
    end

    assign up_xfer = i_valid & i_ready;
    assign dn_xfer = o_valid & o_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (up_xfer && !dn_xfer) begin
            count_q <= count_q + CW'(1);
        end else if (dn_xfer && !up_xfer) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign count = count_q;

    // Simulation-only sanity: legal depth and no X on control inputs out of reset.
    a_ctrl_known : assert property (@(posedge clk)
        rst_n |-> (!$isunknown({i_valid, o_ready, flush})
                   && DEPTH >= MIN_DEPTH && DEPTH <= MAX_DEPTH));

endmodule
